// File: rtl/bus_mem_responder.sv
// Bus-cycle responder with a 256x8 memory window at {BASE_HI, 8'hxx}.
// Each accepted Start runs ADDR, WAIT x WAIT_STATES, DATA, END; all outputs are registered.
module bus_mem_responder #(
    parameter logic [11:0] BASE_HI     = 12'h200,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [19:0] Direction,
    input  logic        RD_WR,
    input  logic [7:0]  Data_in,
    output logic [7:0]  Data_out,
    output logic        Data_oe,
    output logic        Ready,
    output logic        Busy,
    output logic        Fault,
    output logic [15:0] Cycle_Count
);

    typedef enum logic [2:0] {StIdle, StAddr, StWait, StData, StEnd} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [19:0] r_addr;
    logic        r_wr;
    logic [2:0]  r_wait;
    logic [15:0] r_cycle_count;
    logic [7:0]  r_mem [256];
    logic [7:0]  r_data_out;
    logic        r_data_oe;
    logic        r_ready;
    logic        r_busy;
    logic        r_fault;
    logic        w_hit;

    assign w_hit = (r_addr[19:8] == BASE_HI);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (Start) w_state_next = StAddr;
            StAddr:  w_state_next = (WAIT_STATES == 0) ? StData : StWait;
            StWait:  if (r_wait == 3'd1) w_state_next = StData;
            StData:  w_state_next = StEnd;
            StEnd:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_addr        <= '0;
            r_wr          <= 1'b0;
            r_wait        <= '0;
            r_cycle_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StIdle && Start) begin
                r_addr <= Direction;
                r_wr   <= RD_WR;
            end
            if (r_state == StAddr) begin
                r_wait <= 3'(WAIT_STATES);
            end else if (r_state == StWait) begin
                r_wait <= r_wait - 3'd1;
            end
            if (r_state == StEnd) begin
                r_cycle_count <= r_cycle_count + 16'd1;
            end
        end
    end

    // Outputs are decoded from the state being entered so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out <= 8'h00;
            r_data_oe  <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_busy     <= (w_state_next != StIdle);
            r_ready    <= (w_state_next == StData);
            r_fault    <= (w_state_next == StData) && !w_hit;
            r_data_oe  <= (w_state_next == StData) && !r_wr;
            if (w_state_next == StData && !r_wr) begin
                r_data_out <= w_hit ? r_mem[r_addr[7:0]] : 8'hFF;
            end else begin
                r_data_out <= 8'h00;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (r_state == StData && r_wr && w_hit) begin
            r_mem[r_addr[7:0]] <= Data_in;
        end
    end

    assign Data_out    = r_data_out;
    assign Data_oe     = r_data_oe;
    assign Ready       = r_ready;
    assign Busy        = r_busy;
    assign Fault       = r_fault;
    assign Cycle_Count = r_cycle_count;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Drives a WAIT_STATES=1 and a WAIT_STATES=0 responder with shared stimulus and checks both
// every cycle against a phase-count reference model, plus directed literal checks.
module tb_bus_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [19:0] Direction;
    logic        RD_WR;
    logic [7:0]  Data_in;

    logic [7:0]  dout [2];
    logic        oe   [2];
    logic        rdy  [2];
    logic        bsy  [2];
    logic        flt  [2];
    logic [15:0] cc   [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_mem_responder #(.BASE_HI(12'h200), .WAIT_STATES(1)) u_dut0 (
        .clk(clk), .reset(reset), .Start(Start), .Direction(Direction), .RD_WR(RD_WR),
        .Data_in(Data_in), .Data_out(dout[0]), .Data_oe(oe[0]), .Ready(rdy[0]),
        .Busy(bsy[0]), .Fault(flt[0]), .Cycle_Count(cc[0])
    );

    bus_mem_responder #(.BASE_HI(12'h200), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .reset(reset), .Start(Start), .Direction(Direction), .RD_WR(RD_WR),
        .Data_in(Data_in), .Data_out(dout[1]), .Data_oe(oe[1]), .Ready(rdy[1]),
        .Busy(bsy[1]), .Fault(flt[1]), .Cycle_Count(cc[1])
    );

    task automatic chk(input string name, input int k, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    // Reference model: m_ph counts cycles since a Start was accepted (0 = idle).
    int          m_ph   [2];
    logic [19:0] m_addr [2];
    logic        m_wr   [2];
    logic [15:0] m_cnt  [2];
    logic [7:0]  m_mem  [2][256];
    int          wrap_seq = 0;
    int          wrap_seen = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_ph[k] = 0; m_addr[k] = '0; m_wr[k] = 1'b0; m_cnt[k] = '0;
                for (int i = 0; i < 256; i++) m_mem[k][i] = 8'h00;
            end
        end else begin
            if (wrap_seq != wrap_seen) begin
                wrap_seen = wrap_seq;
                m_cnt[0] = 16'hFFFF;
            end
            for (int k = 0; k < 2; k++) begin
                int ws;
                ws = (k == 0) ? 1 : 0;
                if (m_ph[k] == 0) begin
                    if (Start) begin
                        m_addr[k] = Direction; m_wr[k] = RD_WR; m_ph[k] = 1;
                    end
                end else begin
                    if (m_ph[k] == 2 + ws && m_wr[k] && m_addr[k][19:8] == 12'h200)
                        m_mem[k][m_addr[k][7:0]] = Data_in;
                    if (m_ph[k] == 3 + ws) begin
                        m_cnt[k] = m_cnt[k] + 16'd1;
                        m_ph[k] = 0;
                    end else begin
                        m_ph[k]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int ws;
            logic hit, e_rdy, e_oe;
            logic [7:0] e_dout;
            ws     = (k == 0) ? 1 : 0;
            hit    = (m_addr[k][19:8] == 12'h200);
            e_rdy  = (m_ph[k] == 2 + ws);
            e_oe   = e_rdy && !m_wr[k];
            e_dout = !e_oe ? 8'h00 : (hit ? m_mem[k][m_addr[k][7:0]] : 8'hFF);
            chk("busy",  k, 16'(bsy[k]),  16'(m_ph[k] != 0));
            chk("ready", k, 16'(rdy[k]),  16'(e_rdy));
            chk("fault", k, 16'(flt[k]),  16'(e_rdy && !hit));
            chk("oe",    k, 16'(oe[k]),   16'(e_oe));
            chk("dout",  k, 16'(dout[k]), 16'(e_dout));
            chk("count", k, cc[k],        m_cnt[k]);
        end
    end

    logic [7:0] c_dout [2];
    logic       c_oe   [2];
    logic       c_rdy  [2];
    logic       c_flt  [2];
    logic       b_hist [13];

    // Call at posedge+1 with both DUTs idle; captures each DUT's DATA-cycle outputs.
    task automatic bus_op(input logic [19:0] a, input logic w, input logic [7:0] d);
        Direction = a; RD_WR = w; Data_in = d; Start = 1'b1;
        @(posedge clk); #1 Start = 1'b0;
        @(posedge clk); @(negedge clk);
        c_dout[1] = dout[1]; c_oe[1] = oe[1]; c_rdy[1] = rdy[1]; c_flt[1] = flt[1];
        @(posedge clk); @(negedge clk);
        c_dout[0] = dout[0]; c_oe[0] = oe[0]; c_rdy[0] = rdy[0]; c_flt[0] = flt[0];
        @(posedge clk); @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; Direction = '0; RD_WR = 1'b0; Data_in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_busy", 0, 16'(bsy[0]), 16'd0);
        chk("rst_count", 0, cc[0], 16'd0);

        bus_op(20'h20010, 1'b1, 8'hA1);
        bus_op(20'h20010, 1'b0, 8'h00);
        chk("wr_rd_data", 0, 16'(c_dout[0]), 16'h00A1);
        chk("wr_rd_ready", 0, 16'(c_rdy[0]), 16'd1);
        chk("wr_rd_oe", 0, 16'(c_oe[0]), 16'd1);
        chk("wr_rd_count", 0, cc[0], 16'd2);
        chk("wr_rd_data", 1, 16'(c_dout[1]), 16'h00A1);

        bus_op(20'h10010, 1'b0, 8'h00);
        chk("miss_fault", 0, 16'(c_flt[0]), 16'd1);
        chk("miss_data", 0, 16'(c_dout[0]), 16'h00FF);
        bus_op(20'h1FFFF, 1'b1, 8'h55);
        bus_op(20'h200FF, 1'b0, 8'h00);
        chk("miss_nowrite", 0, 16'(c_dout[0]), 16'h0000);
        chk("miss_nowrite_oe", 0, 16'(c_oe[0]), 16'd1);

        bus_op(20'h200FF, 1'b1, 8'hD4);
        bus_op(20'h200FF, 1'b0, 8'h00);
        chk("ws0_ready", 1, 16'(c_rdy[1]), 16'd1);
        chk("ws0_data", 1, 16'(c_dout[1]), 16'h00D4);
        chk("ws0_count", 1, cc[1], 16'd7);

        // Reset lands while dut0 sits in WAIT of a write.
        Direction = 20'h20020; RD_WR = 1'b1; Data_in = 8'hB2; Start = 1'b1;
        @(posedge clk); #1 Start = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        #1;
        chk("rst_mid_busy", 0, 16'(bsy[0]), 16'd0);
        chk("rst_mid_count", 0, cc[0], 16'd0);
        @(posedge clk); #1 reset = 1'b0;
        bus_op(20'h20020, 1'b0, 8'h00);
        chk("rst_mid_data", 0, 16'(c_dout[0]), 16'h0000);
        chk("rst_mid_cnt1", 0, cc[0], 16'd1);

        Direction = 20'h20030; RD_WR = 1'b0; Start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); @(negedge clk);
            b_hist[i] = bsy[0];
        end
        Start = 1'b0;
        chk("hold_count", 0, cc[0], 16'd3);
        chk("hold_busy_end", 0, 16'(b_hist[4]), 16'd1);
        chk("hold_busy_gap", 0, 16'(b_hist[5]), 16'd0);
        chk("hold_busy_next", 0, 16'(b_hist[6]), 16'd1);
        repeat (12) @(posedge clk);
        #1;

        @(negedge clk); #1;
        force u_dut0.r_cycle_count = 16'hFFFF;
        wrap_seq++;
        #1 release u_dut0.r_cycle_count;
        @(posedge clk); #1;
        bus_op(20'h20001, 1'b0, 8'h00);
        chk("wrap_count", 0, cc[0], 16'h0000);

        for (int n = 0; n < 1500; n++) begin
            @(posedge clk); #1;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) reset = 1'b1;
            Start     = ($urandom_range(0, 2) != 0);
            Direction = ($urandom_range(0, 3) != 0) ? {12'h200, 4'h0, 4'($urandom)}
                                                     : 20'($urandom);
            RD_WR     = 1'($urandom);
            Data_in   = 8'($urandom);
        end
        @(posedge clk); #1 reset = 1'b0; Start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
